// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared widths, size encodings and FSM state for the data-memory responder
package dmem_responder_pkg;
  localparam int XLEN = 32;
  localparam int DMEM_AW = 10;
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_R = 2'b11;
  typedef enum logic {IDLE, SPLIT} state_t;
endpackage

// File: rtl/dmem_load_ext.sv
// dmem_load_ext: sign/zero-extends right-aligned load bytes to XLEN
module dmem_load_ext
  import dmem_responder_pkg::*;
(
  input  logic [XLEN-1:0] raw,
  input  logic [1:0]      size,
  input  logic            uns,
  output logic [XLEN-1:0] data
);
  assign data = size == SIZE_B ? {{(XLEN-8){~uns & raw[7]}}, raw[7:0]} :
                size == SIZE_H ? {{(XLEN-16){~uns & raw[15]}}, raw[15:0]} :
                size == SIZE_W ? raw : '0;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: word-organised little-endian data RAM answering MEM-stage loads/stores,
// splitting word-crossing accesses into two beats.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int AW = DMEM_AW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err
);
  logic [XLEN-1:0] mem [2**AW];
  state_t state_q, state_d;
  logic [AW-1:0] w1_q, w1_d, w, wr_idx;
  logic [1:0] off_q, off_d, size_q, size_d, off, ext_off, ext_size;
  logic we_q, we_d, uns_q, uns_d, ext_uns;
  logic [3:0] hmask_q, hmask_d, bm, wr_mask;
  logic [XLEN-1:0] hdata_q, hdata_d, lo_q, lo_d, rd_lo, rd_hi, raw, ext, wr_data, rdata_d;
  logic [7:0] lane;
  logic [2*XLEN-1:0] wsh;
  logic idle, acc, ld, split, wr_en, valid_d, err_d, cur_we;
  logic unused_addr;
  assign unused_addr = ^req_addr[XLEN-1:AW+2];
  assign req_ready = state_q == IDLE;
  dmem_load_ext u_ext (.raw(raw), .size(ext_size), .uns(ext_uns), .data(ext));
  // Lanes 7:4 of the shifted mask/data belong to the following word (second beat).
  always_comb begin
    idle = state_q == IDLE;
    off = req_addr[1:0];
    w = req_addr[AW+1:2];
    bm = req_size == SIZE_B ? 4'h1 : req_size == SIZE_H ? 4'h3 : req_size == SIZE_W ? 4'hf : 4'h0;
    lane = {4'b0, bm} << off;
    wsh = {{XLEN{1'b0}}, req_wdata} << {off, 3'b0};
    split = |lane[7:4];
    acc = idle && req_valid;
    ld = acc && split;
    ext_off = idle ? off : off_q;
    ext_size = idle ? req_size : size_q;
    ext_uns = idle ? req_unsigned : uns_q;
    rd_lo = idle ? mem[w] : lo_q;
    rd_hi = idle ? '0 : mem[w1_q];
    raw = XLEN'({rd_hi, rd_lo} >> {ext_off, 3'b0});
    cur_we = idle ? req_we : we_q;
    wr_en = idle ? acc && req_we : we_q;
    wr_idx = idle ? w : w1_q;
    wr_mask = idle ? lane[3:0] : hmask_q;
    wr_data = idle ? wsh[XLEN-1:0] : hdata_q;
    state_d = ld ? SPLIT : IDLE;
    valid_d = idle ? acc && !split : 1'b1;
    err_d = acc && req_size == SIZE_R;
    rdata_d = valid_d && !cur_we && !err_d ? ext : '0;
    w1_d = ld ? w + AW'(1) : w1_q;
    off_d = ld ? off : off_q;
    size_d = ld ? req_size : size_q;
    we_d = ld ? req_we : we_q;
    uns_d = ld ? req_unsigned : uns_q;
    hmask_d = ld ? lane[7:4] : hmask_q;
    hdata_d = ld ? wsh[2*XLEN-1:XLEN] : hdata_q;
    lo_d = ld ? mem[w] : lo_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err <= 1'b0;
      w1_q <= '0;
      off_q <= '0;
      size_q <= '0;
      we_q <= 1'b0;
      uns_q <= 1'b0;
      hmask_q <= '0;
      hdata_q <= '0;
      lo_q <= '0;
    end else begin
      state_q <= state_d;
      resp_valid <= valid_d;
      resp_rdata <= rdata_d;
      resp_err <= err_d;
      w1_q <= w1_d;
      off_q <= off_d;
      size_q <= size_d;
      we_q <= we_d;
      uns_q <= uns_d;
      hmask_q <= hmask_d;
      hdata_q <= hdata_d;
      lo_q <= lo_d;
    end
  end
  // Array is not reset; writes are suppressed while reset is held so an aborted split never lands.
  always_ff @(posedge clk) begin
    if (wr_en && !reset)
      for (int i = 0; i < 4; i++)
        if (wr_mask[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: table vectors, corner sequences and random traffic against a byte-array model
module tb_dmem_responder;
  localparam int NB = 4096;
  logic clk = 1'b0;
  logic reset, req_valid, req_ready, req_we, req_unsigned, resp_valid, resp_err;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic [1:0] req_size;
  logic [7:0] mem_m [NB];
  int n_cmp = 0, n_bad = 0;
  typedef struct {
    logic we; logic [31:0] a; logic [31:0] d; logic [1:0] sz; logic u;
    logic [31:0] r; logic e; int lat;
  } vec_t;
  vec_t tbl[$];

  dmem_responder dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Byte-addressed memory: an access touches bytes addr..addr+n-1 modulo the RAM size.
  function automatic void model(input bit we, input logic [31:0] a, input logic [31:0] d,
                                input logic [1:0] sz, input bit u,
                                output logic [31:0] r, output bit e, output int lat);
    int n;
    logic [11:0] p;
    r = '0; e = 1'b0; lat = 1;
    if (sz == 2'b11) begin
      e = 1'b1;
      return;
    end
    n = 1 << sz;
    if (int'(a[1:0]) + n > 4) lat = 2;
    for (int i = 0; i < n; i++) begin
      p = a[11:0] + 12'(i);
      if (we) mem_m[p] = d[8*i +: 8];
      else r[8*i +: 8] = mem_m[p];
    end
    if (!we && !u && n < 4 && r[8*n-1]) r = r | (32'hffffffff << (8*n));
  endfunction

  task automatic xact(input string nm, input bit we, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] sz, input bit u, input bit use_mdl,
                      input logic [31:0] er, input bit ee, input int el);
    logic [31:0] mr;
    bit me, got;
    int ml, lat;
    model(we, a, d, sz, u, mr, me, ml);
    if (use_mdl) begin
      er = mr; ee = me; el = ml;
    end
    @(negedge clk);
    chk({nm, " ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_size = sz; req_unsigned = u;
    @(posedge clk);
    #1 req_valid = 1'b0;
    got = 1'b0; lat = 0;
    for (int c = 1; c <= 4 && !got; c++) begin
      @(negedge clk);
      if (c == 1) chk({nm, " ready_after"}, 32'(req_ready), 32'(el == 1));
      if (resp_valid) begin
        got = 1'b1; lat = c;
        chk({nm, " rdata"}, resp_rdata, er);
        chk({nm, " err"}, 32'(resp_err), 32'(ee));
      end
    end
    chk({nm, " latency"}, 32'(lat), 32'(el));
  endtask

  initial begin
    logic [31:0] mr, a;
    bit me, seen;
    int ml;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = 2'b10; req_unsigned = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst ready", 32'(req_ready), 32'd1);
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst rdata", resp_rdata, 32'd0);
    chk("rst err", 32'(resp_err), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < NB / 4; i++) xact("fill", 1'b1, 32'(4 * i), $urandom, 2'b10, 1'b0, 1'b1, 0, 0, 0);

    tbl.push_back('{1'b1, 32'h20, 32'h11223344, 2'd2, 1'b0, 32'h0, 1'b0, 1});
    tbl.push_back('{1'b1, 32'h21, 32'h00000080, 2'd0, 1'b0, 32'h0, 1'b0, 1});
    tbl.push_back('{1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 32'h11228044, 1'b0, 1});
    tbl.push_back('{1'b0, 32'h21, 32'h0, 2'd0, 1'b0, 32'hffffff80, 1'b0, 1});
    tbl.push_back('{1'b0, 32'h21, 32'h0, 2'd0, 1'b1, 32'h00000080, 1'b0, 1});
    tbl.push_back('{1'b1, 32'h31, 32'h0000a5a5, 2'd1, 1'b0, 32'h0, 1'b0, 1});
    tbl.push_back('{1'b0, 32'h31, 32'h0, 2'd1, 1'b0, 32'hffffa5a5, 1'b0, 1});
    tbl.push_back('{1'b0, 32'h31, 32'h0, 2'd1, 1'b1, 32'h0000a5a5, 1'b0, 1});
    tbl.push_back('{1'b1, 32'h40, 32'h0, 2'd2, 1'b0, 32'h0, 1'b0, 1});
    tbl.push_back('{1'b1, 32'h44, 32'h0, 2'd2, 1'b0, 32'h0, 1'b0, 1});
    tbl.push_back('{1'b1, 32'h42, 32'h04030201, 2'd2, 1'b0, 32'h0, 1'b0, 2});
    tbl.push_back('{1'b0, 32'h40, 32'h0, 2'd2, 1'b0, 32'h02010000, 1'b0, 1});
    tbl.push_back('{1'b0, 32'h44, 32'h0, 2'd2, 1'b0, 32'h00000403, 1'b0, 1});
    tbl.push_back('{1'b0, 32'h42, 32'h0, 2'd2, 1'b0, 32'h04030201, 1'b0, 2});
    tbl.push_back('{1'b0, 32'h43, 32'h0, 2'd1, 1'b0, 32'h00000302, 1'b0, 2});
    tbl.push_back('{1'b1, 32'h20, 32'hffffffff, 2'd3, 1'b0, 32'h0, 1'b1, 1});
    tbl.push_back('{1'b0, 32'h43, 32'h0, 2'd3, 1'b0, 32'h0, 1'b1, 1});
    tbl.push_back('{1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 32'h11228044, 1'b0, 1});
    tbl.push_back('{1'b1, 32'h0, 32'h0, 2'd2, 1'b0, 32'h0, 1'b0, 1});
    tbl.push_back('{1'b1, 32'hffc, 32'h0, 2'd2, 1'b0, 32'h0, 1'b0, 1});
    tbl.push_back('{1'b1, 32'hffe, 32'hcafebabe, 2'd2, 1'b0, 32'h0, 1'b0, 2});
    tbl.push_back('{1'b0, 32'h0, 32'h0, 2'd2, 1'b0, 32'h0000cafe, 1'b0, 1});
    tbl.push_back('{1'b0, 32'hffc, 32'h0, 2'd2, 1'b0, 32'hbabe0000, 1'b0, 1});
    tbl.push_back('{1'b0, 32'h1000, 32'h0, 2'd2, 1'b0, 32'h0000cafe, 1'b0, 1});
    foreach (tbl[i])
      xact($sformatf("vec%0d", i), tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].sz, tbl[i].u, 1'b0,
           tbl[i].r, tbl[i].e, tbl[i].lat);

    // Back-to-back aligned store then load with req_valid held high.
    model(1'b1, 32'h10, 32'hdeadbeef, 2'd2, 1'b0, mr, me, ml);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'hdeadbeef; req_size = 2'd2;
    req_unsigned = 1'b0;
    @(posedge clk);
    #1 req_we = 1'b0; req_wdata = '0;
    @(negedge clk);
    chk("b2b ready", 32'(req_ready), 32'd1);
    chk("b2b st valid", 32'(resp_valid), 32'd1);
    chk("b2b st rdata", resp_rdata, 32'd0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("b2b ld valid", 32'(resp_valid), 32'd1);
    chk("b2b ld rdata", resp_rdata, 32'hdeadbeef);

    // Reset during SPLIT: only the first beat (byte 0x83) may land.
    xact("rs0", 1'b1, 32'h80, 32'h0, 2'd2, 1'b0, 1'b1, 0, 0, 0);
    xact("rs1", 1'b1, 32'h84, 32'h0, 2'd2, 1'b0, 1'b1, 0, 0, 0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h83; req_wdata = 32'haabbccdd; req_size = 2'd2;
    @(posedge clk);
    #1 req_valid = 1'b0; reset = 1'b1;
    mem_m[12'h83] = 8'hdd;
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      seen = seen | resp_valid;
    end
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | resp_valid;
    end
    chk("rst_split no resp", 32'(seen), 32'd0);
    chk("rst_split ready", 32'(req_ready), 32'd1);
    xact("rst_split w84", 1'b0, 32'h84, 32'h0, 2'd2, 1'b0, 1'b0, 32'h0, 1'b0, 1);
    xact("rst_split w80", 1'b0, 32'h80, 32'h0, 2'd2, 1'b0, 1'b0, 32'hdd000000, 1'b0, 1);

    for (int i = 0; i < 400; i++) begin
      a = 32'($urandom_range(0, NB - 1)) | (($urandom % 4 == 0) ? 32'h12340000 : 32'h0);
      xact("rnd", 1'($urandom % 2), a, $urandom, 2'($urandom_range(0, 3)), 1'($urandom % 2),
           1'b1, 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the pipelined xgriscv core. It answers the load/store requests the MEM stage issues: address, write enable, write data, byte/half/word size and unsigned-load flag.
- Storage is a synchronous, word-organised, little-endian RAM.
- Loads return sign- or zero-extended data one cycle after acceptance.
- Accesses that cross a word boundary are split into two internal beats by a small FSM, with backpressure through req_ready.

Parameters:
- XLEN, 32, data/address width (from shared defines).
- AW, 10, word-index width; depth = 2**AW words (4 KiB default).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data, right-aligned (byte in [7:0], half in [15:0]).
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  in  1  loads only: zero-extend if 1, sign-extend if 0.
- resp_valid  out  1  one-cycle pulse: request completed.
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid: reserved size encoding.

Behaviour:
- Handshake and addressing
  - A request is accepted on a rising edge where req_valid && req_ready.
  - req_ready = (state == IDLE), combinational from state only.
  - Word index = req_addr[AW+1:2]; higher address bits are ignored, so addresses alias modulo 2**(AW+2).
  - Byte offset = req_addr[1:0].
  - bytes = 1/2/4 for size 00/01/10.
  - Split is required when offset + bytes > 4.
- States
  - IDLE: accepts a request.
    - Non-split request: performed entirely at the acceptance edge (store bytes written under a byte mask; load word read). resp_valid is asserted in the next cycle (N+1). State stays IDLE, so throughput is one request per cycle.
    - Split request: first beat is performed on word w (bytes offset..3). Address, size, we, unsigned and remaining wdata bytes are latched, plus the low read bytes for a load. Go to SPLIT.
  - SPLIT: lasts exactly one cycle with req_ready = 0.
    - Second beat on word (w+1) mod 2**AW, bytes 0..(offset+bytes-5).
    - resp_valid is asserted in the cycle after SPLIT (N+2). Return to IDLE.
- Stores
  - Only the masked byte lanes change; other bytes keep their prior value.
  - resp_rdata = 0 on the response.
- Loads
  - Bytes are assembled little-endian, then extended from bit 7 (byte) or bit 15 (half) per req_unsigned.
  - Word loads are not extended.
- Reserved size (11)
  - No memory access.
  - Response at N+1 with resp_err = 1 and resp_rdata = 0.
  - Never causes a split.
- Same-cycle hazard: a store accepted at edge N is visible to a load accepted at edge N+1. The array is written at the edge, so there is no bypass requirement beyond normal RAM ordering.
- Wrap-around: a split at word 2**AW-1 takes its second beat at word 0.
- Reset
  - Drives state = IDLE, resp_valid = 0, resp_rdata = 0, resp_err = 0, split latches = 0, so req_ready = 1 out of reset.
  - Memory contents are not reset.
  - Reset asserted while in SPLIT aborts the access: the second beat is never written and no response is generated. A split store's first beat remains written.
- Outputs are registered except req_ready.

Decomposition:
- Shared defines file (xgriscv_defines.v) holds:
  - size encodings SIZE_B = 2'b00, SIZE_H = 2'b01, SIZE_W = 2'b10;
  - XLEN;
  - DMEM_AW default.
- One sub-module: dmem_load_ext. It is combinational and takes the assembled raw bytes, size and unsigned flag and returns the extended XLEN result. The same module is reused for the non-split and split paths.
- Lane-mask generation stays inline.

Test Plan:
- Aligned word: sw 0xDEADBEEF @0x10, then lw @0x10 -> resp_valid at N+1 each; rdata = 0xDEADBEEF; back-to-back accepted with req_ready held at 1.
- Byte extend: sb 0x80 @0x21 over word 0x11223344 -> word becomes 0x11228044; lb @0x21 -> 0xFFFFFF80; lbu -> 0x00000080.
- Half inside word, no split: sh 0xA5A5 @0x31 -> bytes 1..2 written; lh @0x31 -> 0xFFFFA5A5; req_ready never drops.
- Crossing split: word 0x40 = 0, word 0x44 = 0; sw 0x04030201 @0x42 -> req_ready = 0 at N+1, resp at N+2; words become 0x02010000 and 0x00000403; lw @0x42 -> 0x04030201 at N+2.
- Wrap + reserved: sw @(4*2**AW-2) splits, and its second beat updates word 0 bytes 0..1. req_size = 11 -> resp_err = 1, rdata = 0, memory unchanged.
- Reset in SPLIT: split store accepted, reset pulsed during SPLIT -> no resp_valid; second word unchanged; req_ready = 1 after release.
